// File: rtl/peripheral_counter_pkg.sv
// Shared constants and config-register layout for the counter peripheral.
package peripheral_counter_pkg;

  localparam int unsigned COUNT_W_DEFAULT      = 32;
  localparam int unsigned LT_THRESHOLD_DEFAULT = 1000;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef struct packed {
    logic en;
    logic dir;
    logic ire;
  } counter_cfg_t;

endpackage

// File: rtl/peripheral_counter_prescaler.sv
// Divides the enabled clock by PRESCALE; tick marks the last cycle of each period.
module peripheral_counter_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // tick ignores clr: a same-edge write may still consume or override this step
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (!en || clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/peripheral_counter_core.sv
// Register-side responder: count/config/pending registers, prescaled up/down
// counter, below-threshold status and wrap interrupt.
module peripheral_counter_core
  import peripheral_counter_pkg::*;
#(
  parameter int unsigned COUNT_W      = COUNT_W_DEFAULT,
  parameter int unsigned PRESCALE     = 1,
  parameter int unsigned LT_THRESHOLD = LT_THRESHOLD_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               count_we,
  input  logic               count_config_we,
  input  logic [COUNT_W-1:0] count_in,
  input  logic               count_en_in,
  input  logic               count_dir_in,
  input  logic               count_ire_in,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_en_out,
  output logic               count_dir_out,
  output logic               count_ire_out,
  output logic               count_lt_1k_out,
  output logic               irq_out
);

  localparam logic [63:0] THR = 64'(LT_THRESHOLD);

  logic [COUNT_W-1:0] count_q, count_d;
  counter_cfg_t       cfg_q, cfg_d;
  logic               wrap_q, wrap_d;
  logic               tick;

  peripheral_counter_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (cfg_q.en),
    .clr   (count_we || count_config_we),
    .tick  (tick)
  );

  always_comb begin
    count_d = count_q;
    cfg_d   = cfg_q;
    wrap_d  = wrap_q;
    if (tick) begin
      if (cfg_q.dir == DIR_UP) begin
        count_d = count_q + COUNT_W'(1);
        if (&count_q) wrap_d = 1'b1;
      end else begin
        count_d = count_q - COUNT_W'(1);
        if (~|count_q) wrap_d = 1'b1;
      end
    end
    // host write wins over a coincident step and drops any pending wrap
    if (count_we) begin
      count_d = count_in;
      wrap_d  = 1'b0;
    end
    if (count_config_we) begin
      cfg_d.en  = count_en_in;
      cfg_d.dir = count_dir_in;
      cfg_d.ire = count_ire_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      cfg_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      cfg_q   <= cfg_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_out       = count_q;
  assign count_en_out    = cfg_q.en;
  assign count_dir_out   = cfg_q.dir;
  assign count_ire_out   = cfg_q.ire;
  assign count_lt_1k_out = (64'(count_q) < THR);
  assign irq_out         = wrap_q & cfg_q.ire;

endmodule

// File: tb/tb_peripheral_counter_core.sv
// Bench: two instances (PRESCALE 1 and 4) on shared stimulus, checked against
// a behavioural model plus directed tables and sequences.
module tb_peripheral_counter_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        count_we, count_config_we;
  logic [31:0] count_in;
  logic        en_in, dir_in, ire_in;

  logic [31:0] a_cnt, b_cnt;
  logic        a_en, a_dir, a_ire, a_lt, a_irq;
  logic        b_en, b_dir, b_ire, b_lt, b_irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  peripheral_counter_core #(.COUNT_W(32), .PRESCALE(1), .LT_THRESHOLD(1000)) dut_a (
    .clk(clk), .reset(reset), .count_we(count_we), .count_config_we(count_config_we),
    .count_in(count_in), .count_en_in(en_in), .count_dir_in(dir_in), .count_ire_in(ire_in),
    .count_out(a_cnt), .count_en_out(a_en), .count_dir_out(a_dir), .count_ire_out(a_ire),
    .count_lt_1k_out(a_lt), .irq_out(a_irq));

  peripheral_counter_core #(.COUNT_W(32), .PRESCALE(4), .LT_THRESHOLD(1000)) dut_b (
    .clk(clk), .reset(reset), .count_we(count_we), .count_config_we(count_config_we),
    .count_in(count_in), .count_en_in(en_in), .count_dir_in(dir_in), .count_ire_in(ire_in),
    .count_out(b_cnt), .count_en_out(b_en), .count_dir_out(b_dir), .count_ire_out(b_ire),
    .count_lt_1k_out(b_lt), .irq_out(b_irq));

  typedef struct {
    logic [31:0] cnt;
    bit          en, dir, ire, pend;
    int          phase;  // enabled cycles since last step/clear
  } mdl_t;

  mdl_t m[2];
  int   ps[2] = '{1, 4};

  typedef struct {
    bit          we, cw;
    logic [31:0] cin;
    bit          en, dir, ire;
    logic [31:0] ec;
    bit          elt, eirq;
  } vec_t;

  vec_t tbl[10];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.cnt = 0; r.en = 0; r.dir = 0; r.ire = 0; r.pend = 0; r.phase = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t s, int p, bit we, bit cw, logic [31:0] cin,
                                    bit en, bit dir, bit ire);
    mdl_t r = s;
    bit   step = s.en && (s.phase == p - 1);
    if (!s.en || we || cw) r.phase = 0;
    else                   r.phase = (s.phase + 1) % p;
    if (we) begin
      r.cnt  = cin;
      r.pend = 0;
    end else if (step) begin
      if (s.dir) begin
        if (s.cnt == 32'd0) r.pend = 1;
        r.cnt = s.cnt - 32'd1;
      end else begin
        if (s.cnt == 32'hFFFF_FFFF) r.pend = 1;
        r.cnt = s.cnt + 32'd1;
      end
    end
    if (cw) begin
      r.en = en; r.dir = dir; r.ire = ire;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_mdl();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] c;
      logic        e, d, i, lt, irq;
      c   = (k == 0) ? a_cnt : b_cnt;
      e   = (k == 0) ? a_en  : b_en;
      d   = (k == 0) ? a_dir : b_dir;
      i   = (k == 0) ? a_ire : b_ire;
      lt  = (k == 0) ? a_lt  : b_lt;
      irq = (k == 0) ? a_irq : b_irq;
      chk($sformatf("mdl%0d_count", k), c, m[k].cnt);
      chk($sformatf("mdl%0d_en", k), 32'(e), 32'(m[k].en));
      chk($sformatf("mdl%0d_dir", k), 32'(d), 32'(m[k].dir));
      chk($sformatf("mdl%0d_ire", k), 32'(i), 32'(m[k].ire));
      chk($sformatf("mdl%0d_lt", k), 32'(lt), 32'(m[k].cnt < 32'd1000));
      chk($sformatf("mdl%0d_irq", k), 32'(irq), 32'(m[k].pend && m[k].ire));
    end
  endtask

  task automatic drive(input bit we, input bit cw, input logic [31:0] cin,
                       input bit en, input bit dir, input bit ire);
    count_we = we; count_config_we = cw; count_in = cin;
    en_in = en; dir_in = dir; ire_in = ire;
  endtask

  task automatic idle();
    drive(0, 0, 32'd0, 0, 0, 0);
  endtask

  // one clock: model advances on the edge, outputs compared 1 time unit later
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      m[k] = mdl_next(m[k], ps[k], count_we, count_config_we, count_in, en_in, dir_in, ire_in);
    #1;
    chk_mdl();
  endtask

  task automatic step_n(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  initial begin
    // wrap/threshold table for the PRESCALE=1 instance, starting from reset state
    tbl[0] = '{1, 1, 32'd998,        1, 0, 0, 32'd998,        1, 0};
    tbl[1] = '{0, 0, 32'd0,          0, 0, 0, 32'd999,        1, 0};
    tbl[2] = '{0, 0, 32'd0,          0, 0, 0, 32'd1000,       0, 0};
    tbl[3] = '{1, 1, 32'hFFFF_FFFE,  1, 0, 1, 32'hFFFF_FFFE,  0, 0};
    tbl[4] = '{0, 0, 32'd0,          0, 0, 0, 32'hFFFF_FFFF,  0, 0};
    tbl[5] = '{0, 0, 32'd0,          0, 0, 0, 32'd0,          1, 1};
    tbl[6] = '{0, 0, 32'd0,          0, 0, 0, 32'd1,          1, 1};
    tbl[7] = '{1, 0, 32'd5,          0, 0, 0, 32'd5,          1, 0};
    tbl[8] = '{0, 1, 32'd0,          0, 0, 1, 32'd6,          1, 0};
    tbl[9] = '{0, 0, 32'd0,          0, 0, 0, 32'd6,          1, 0};

    // 1: reset then idle
    idle();
    reset = 1'b0;
    m[0] = mdl_reset(); m[1] = mdl_reset();
    #23;
    reset = 1'b1;
    step_n(10);
    chk("t1_count", a_cnt, 32'd0);
    chk("t1_cfg", 32'({a_en, a_dir, a_ire}), 32'd0);
    chk("t1_lt", 32'(a_lt), 32'd1);
    chk("t1_irq", 32'(a_irq), 32'd0);

    // 2/3: threshold crossing, up-wrap interrupt, count_we clears pending
    for (int r = 0; r < 10; r++) begin
      drive(tbl[r].we, tbl[r].cw, tbl[r].cin, tbl[r].en, tbl[r].dir, tbl[r].ire);
      step();
      chk($sformatf("tbl%0d_count", r), a_cnt, tbl[r].ec);
      chk($sformatf("tbl%0d_lt", r), 32'(a_lt), 32'(tbl[r].elt));
      chk($sformatf("tbl%0d_irq", r), 32'(a_irq), 32'(tbl[r].eirq));
    end

    // 4: PRESCALE=4 down count, pause and re-enable
    drive(1, 1, 32'd10, 1, 1, 0); step(); idle();
    chk("t4_load", b_cnt, 32'd10);
    step_n(3); chk("t4_hold3", b_cnt, 32'd10);
    step();    chk("t4_9", b_cnt, 32'd9);
    step_n(4); chk("t4_8", b_cnt, 32'd8);
    step_n(4); chk("t4_7", b_cnt, 32'd7);
    step_n(2);
    drive(0, 1, 32'd0, 0, 1, 0); step(); idle();
    step_n(3); chk("t4_paused", b_cnt, 32'd7);
    drive(0, 1, 32'd0, 1, 1, 0); step(); idle();
    step_n(3); chk("t4_reen3", b_cnt, 32'd7);
    step();    chk("t4_reen4", b_cnt, 32'd6);

    // 5: write beats tick; config on tick edge uses old dir
    drive(1, 1, 32'd50, 1, 0, 0); step(); idle();
    step();                             chk("t5_51", a_cnt, 32'd51);
    drive(1, 0, 32'd100, 0, 0, 0); step(); idle();
    chk("t5_we_wins", a_cnt, 32'd100);
    step();                             chk("t5_101", a_cnt, 32'd101);
    drive(0, 1, 32'd0, 1, 1, 0); step(); idle();
    chk("t5_old_dir", a_cnt, 32'd102);
    step();                             chk("t5_new_dir", a_cnt, 32'd101);

    // 6: wrap with ire=0, later ire=1 raises irq; async reset mid-run
    drive(1, 1, 32'hFFFF_FFFF, 1, 0, 0); step(); idle();
    step(); chk("t6_wrap_cnt", a_cnt, 32'd0); chk("t6_irq_off", 32'(a_irq), 32'd0);
    drive(0, 1, 32'd0, 0, 0, 1); step(); idle();
    chk("t6_irq_on", 32'(a_irq), 32'd1);
    drive(0, 1, 32'd0, 1, 1, 1); step(); idle();
    step_n(2);
    #2 reset = 1'b0;
    #1;
    m[0] = mdl_reset(); m[1] = mdl_reset();
    chk("t6_rst_count", a_cnt, 32'd0);
    chk("t6_rst_cfg", 32'({a_en, a_dir, a_ire}), 32'd0);
    chk("t6_rst_lt", 32'(a_lt), 32'd1);
    chk("t6_rst_irq", 32'(a_irq), 32'd0);
    chk_mdl();
    #1 reset = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] cin;
      case ($urandom_range(0, 3))
        0:       cin = $urandom;
        1:       cin = 32'd995 + 32'($urandom_range(0, 10));
        2:       cin = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        default: cin = 32'($urandom_range(0, 7));
      endcase
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, cin,
            $urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom));
      step();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
